qcw_burst_sequencer: RTL

Burst-level initiator for the QCW PLL/oscillator block. It accepts a fire request, issues the one-cycle start, programs the cycle limit, and ramps the phase-shift command one LSB at a time toward a target as the PLL reports finished cycles. It forwards over-current as halt, handles done and fault, and enforces a holdoff between bursts. It sits between the interrupter/UI logic and the PLL.

---
 rtl/qcw_burst_sequencer.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/qcw_burst_sequencer.sv
// qcw_burst_sequencer: burst-level initiator for the QCW PLL/oscillator block.
//
// Accepts a fire request in IDLE, pulses pll_start for one clock, programs the PLL
// cycle limit and ramps pll_phase_shift one LSB at a time toward a target as the PLL
// reports finished cycles. Over-current is forwarded as pll_halt. PLL done/fault are
// handled and a holdoff is enforced after every burst end or fault clear.
//
// Parameters:
//   HOLDOFF_CLKS  idle clocks spent in HOLDOFF (must be >= 1)
//   WDOG_CLKS     max clocks between pll_cycle_finished pulses in RUN (watchdog build)
//
// Optional feature macro: QCW_BURST_WDOG_EN enables the RUN-state cycle watchdog
// (fault_code 2). Without it no watchdog logic exists and WDOG_CLKS is only range-checked.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   fire                  burst request, level-sampled in IDLE only
//   burst_cycles[15:0]    cycle limit for the burst, 0 means do not fire
//   ramp_start/end[7:0]   phase-shift command at start / ramp target
//   ramp_div[7:0]         finished cycles per 1-LSB phase step (0 treated as 1)
//   ocp                   over-current flag
//   fault_clear           releases FAULT
//   pll_cycle_finished    PLL per-cycle pulse
//   pll_done, pll_fault   PLL sticky status (stale until the PLL sees the next start)
//   pll_start             one-clock start pulse
//   pll_halt              halt request to the PLL
//   pll_phase_shift[7:0]  current phase command
//   pll_cycle_limit[15:0] latched burst_cycles
//   busy                  high in any state except IDLE
//   fault_code[1:0]       0 none, 1 PLL fault, 2 watchdog, 3 PLL fault with ocp seen
//   burst_count[15:0]     completed (non-fault) bursts, wrapping
module qcw_burst_sequencer #(
    parameter int unsigned HOLDOFF_CLKS = 100000,
    parameter int unsigned WDOG_CLKS    = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fire,
    input  logic [15:0] burst_cycles,
    input  logic [7:0]  ramp_start,
    input  logic [7:0]  ramp_end,
    input  logic [7:0]  ramp_div,
    input  logic        ocp,
    input  logic        fault_clear,
    input  logic        pll_cycle_finished,
    input  logic        pll_done,
    input  logic        pll_fault,
    output logic        pll_start,
    output logic        pll_halt,
    output logic [7:0]  pll_phase_shift,
    output logic [15:0] pll_cycle_limit,
    output logic        busy,
    output logic [1:0]  fault_code,
    output logic [15:0] burst_count
);

    localparam int unsigned HoldW = (HOLDOFF_CLKS > 1) ? $clog2(HOLDOFF_CLKS) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLDOFF_CLKS - 1);

    if (HOLDOFF_CLKS == 0 || WDOG_CLKS == 0) begin : g_bad_cfg
        $error("qcw_burst_sequencer: HOLDOFF_CLKS and WDOG_CLKS must be non-zero");
    end

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StSettle,
        StRun,
        StHoldoff,
        StFault
    } state_e;

    state_e           state_q, state_d;
    logic             settle_q, settle_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]       div_cnt_q, div_cnt_d;
    logic [7:0]       ramp_div_q, ramp_div_d;
    logic [7:0]       ramp_end_q, ramp_end_d;
    logic             ocp_seen_q, ocp_seen_d;
    logic             start_q, start_d;
    logic             halt_q, halt_d;
    logic [7:0]       phase_q, phase_d;
    logic [15:0]      limit_q, limit_d;
    logic             busy_q, busy_d;
    logic [1:0]       fcode_q, fcode_d;
    logic [15:0]      count_q, count_d;
    logic [7:0]       div_last;

`ifdef QCW_BURST_WDOG_EN
    localparam int unsigned WdogW = (WDOG_CLKS > 1) ? $clog2(WDOG_CLKS) : 1;
    localparam logic [WdogW-1:0] WdogLast = WdogW'(WDOG_CLKS - 1);
    logic [WdogW-1:0] wdog_q, wdog_d;
    logic             wdog_hit;
`endif

    // ramp_div of 0 behaves as 1: step on every finished pulse
    assign div_last = (ramp_div_q == 8'd0) ? 8'd0 : ramp_div_q - 8'd1;

`ifdef QCW_BURST_WDOG_EN
    assign wdog_hit = !pll_cycle_finished && (wdog_q == WdogLast);
`endif

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        hold_cnt_d = hold_cnt_q;
        div_cnt_d  = div_cnt_q;
        ramp_div_d = ramp_div_q;
        ramp_end_d = ramp_end_q;
        ocp_seen_d = ocp_seen_q;
        start_d    = 1'b0;
        halt_d     = halt_q;
        phase_d    = phase_q;
        limit_d    = limit_q;
        fcode_d    = fcode_q;
        count_d    = count_q;
`ifdef QCW_BURST_WDOG_EN
        wdog_d     = wdog_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (fire && burst_cycles != 16'd0) begin
                    limit_d    = burst_cycles;
                    phase_d    = ramp_start;
                    ramp_end_d = ramp_end;
                    ramp_div_d = ramp_div;
                    div_cnt_d  = 8'd0;
                    ocp_seen_d = 1'b0;
                    start_d    = 1'b1;
                    state_d    = StArm;
`ifdef QCW_BURST_WDOG_EN
                    wdog_d     = '0;
`endif
                end
            end

            StArm: begin
                settle_d = 1'b0;
                state_d  = StSettle;
            end

            // Two clocks; PLL done/fault are still stale from the previous burst here.
            StSettle: begin
                if (settle_q) begin
                    state_d = StRun;
`ifdef QCW_BURST_WDOG_EN
                    wdog_d  = '0;
`endif
                end else begin
                    settle_d = 1'b1;
                end
            end

            StRun: begin
                if (pll_cycle_finished) begin
                    if (div_cnt_q == div_last) begin
                        div_cnt_d = 8'd0;
                        if (phase_q < ramp_end_q) begin
                            phase_d = phase_q + 8'd1;
                        end else if (phase_q > ramp_end_q) begin
                            phase_d = phase_q - 8'd1;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + 8'd1;
                    end
                end
                if (ocp) begin
                    halt_d     = 1'b1;
                    ocp_seen_d = 1'b1;
                end
`ifdef QCW_BURST_WDOG_EN
                wdog_d = pll_cycle_finished ? '0 : wdog_q + 1'b1;
`endif
                // Fault wins over a simultaneous done.
                if (pll_fault) begin
                    fcode_d = (ocp_seen_q || ocp) ? 2'd3 : 2'd1;
                    halt_d  = 1'b0;
                    state_d = StFault;
                end else if (pll_done) begin
                    count_d    = count_q + 16'd1;
                    halt_d     = 1'b0;
                    hold_cnt_d = '0;
                    state_d    = StHoldoff;
                end
`ifdef QCW_BURST_WDOG_EN
                else if (wdog_hit) begin
                    // Halt is held for the transition clock, then dropped in FAULT.
                    fcode_d = 2'd2;
                    halt_d  = 1'b1;
                    state_d = StFault;
                end
`endif
            end

            StHoldoff: begin
                if (hold_cnt_q == HoldLast) begin
                    state_d = StIdle;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            StFault: begin
                halt_d = 1'b0;
                if (fault_clear) begin
                    fcode_d    = 2'd0;
                    hold_cnt_d = '0;
                    state_d    = StHoldoff;
                end
            end

            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            settle_q   <= 1'b0;
            hold_cnt_q <= '0;
            div_cnt_q  <= 8'd0;
            ramp_div_q <= 8'd0;
            ramp_end_q <= 8'd0;
            ocp_seen_q <= 1'b0;
            start_q    <= 1'b0;
            halt_q     <= 1'b0;
            phase_q    <= 8'd0;
            limit_q    <= 16'd0;
            busy_q     <= 1'b0;
            fcode_q    <= 2'd0;
            count_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            hold_cnt_q <= hold_cnt_d;
            div_cnt_q  <= div_cnt_d;
            ramp_div_q <= ramp_div_d;
            ramp_end_q <= ramp_end_d;
            ocp_seen_q <= ocp_seen_d;
            start_q    <= start_d;
            halt_q     <= halt_d;
            phase_q    <= phase_d;
            limit_q    <= limit_d;
            busy_q     <= busy_d;
            fcode_q    <= fcode_d;
            count_q    <= count_d;
        end
    end

`ifdef QCW_BURST_WDOG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

    assign pll_start       = start_q;
    assign pll_halt        = halt_q;
    assign pll_phase_shift = phase_q;
    assign pll_cycle_limit = limit_q;
    assign busy            = busy_q;
    assign fault_code      = fcode_q;
    assign burst_count     = count_q;

endmodule
